// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage.
// Drives the data RAM, extracts load data and builds the MEM->WB bus.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic         MEM_valid,
  input  logic [157:0] EXE_MEM_bus_r,
  input  logic         MEM_next,
  input  logic         cancel,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_wdata,
  input  logic [31:0]  dm_rdata,
  output logic         MEM_over,
  output logic [153:0] MEM_WB_bus,
  output logic [4:0]   MEM_wdest,
  output logic [31:0]  MEM_pc
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic        load, store, sgn;
  logic [1:0]  size;
  logic [31:0] store_data, exe_result, lo_result, pc;
  logic [5:0]  ctl_bits;
  logic [7:0]  cp0r_addr;
  logic        rf_wen, syscall, eret, brk, ov;
  logic [4:0]  rf_wdest;
  logic        unused_ok;

  assign load       = EXE_MEM_bus_r[157];
  assign store      = EXE_MEM_bus_r[156];
  assign size       = EXE_MEM_bus_r[155:154];
  assign sgn        = EXE_MEM_bus_r[153];
  assign unused_ok  = EXE_MEM_bus_r[152];
  assign store_data = EXE_MEM_bus_r[151:120];
  assign exe_result = EXE_MEM_bus_r[119:88];
  assign lo_result  = EXE_MEM_bus_r[87:56];
  assign ctl_bits   = EXE_MEM_bus_r[55:50];
  assign cp0r_addr  = EXE_MEM_bus_r[49:42];
  assign syscall    = EXE_MEM_bus_r[41];
  assign eret       = EXE_MEM_bus_r[40];
  assign rf_wen     = EXE_MEM_bus_r[39];
  assign rf_wdest   = EXE_MEM_bus_r[38:34];
  assign pc         = EXE_MEM_bus_r[33:2];
  assign brk        = EXE_MEM_bus_r[1];
  assign ov         = EXE_MEM_bus_r[0];

  logic        is_half, is_word, misalign, adel, ades;
  logic [31:0] badvaddr;

  assign is_half  = (size == 2'b01);
  assign is_word  = size[1];
  assign misalign = (is_half & exe_result[0]) |
                    (is_word & (exe_result[1:0] != 2'b00));
  assign adel     = load & misalign;
  assign ades     = store & misalign;
  assign badvaddr = (adel | ades) ? exe_result : 32'h0;

  assign dm_addr = exe_result;

  logic [3:0] wen_raw;
  logic       wen_en;

  // Byte lanes and replicated write data for the store width
  always_comb begin
    wen_raw  = 4'b1111;
    dm_wdata = store_data;
    if (!is_word) begin
      if (is_half) begin
        wen_raw  = 4'b0011 << exe_result[1:0];
        dm_wdata = {2{store_data[15:0]}};
      end else begin
        wen_raw  = 4'b0001 << exe_result[1:0];
        dm_wdata = {4{store_data[7:0]}};
      end
    end
  end

  assign dm_wen = wen_en ? wen_raw : 4'b0000;

  logic [31:0] shifted, load_ext, load_reg;
  logic        capture;

  assign shifted = dm_rdata >> {exe_result[1:0], 3'b000};

  // Align and extend the returned RAM word
  always_comb begin
    load_ext = dm_rdata;
    if (!is_word) begin
      if (is_half)
        load_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
      else
        load_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
    end
  end

  // Next state, completion and write strobe
  always_comb begin
    state_nxt = state;
    MEM_over  = 1'b0;
    wen_en    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (MEM_valid & ~cancel) begin
          if (load & ~adel) begin
            state_nxt = LOAD_WAIT;
          end else begin
            MEM_over  = 1'b1;
            wen_en    = store & ~ades;
            state_nxt = MEM_next ? IDLE : HOLD;
          end
        end
      end
      LOAD_WAIT: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          capture   = 1'b1;
          MEM_over  = 1'b1;
          state_nxt = MEM_next ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          MEM_over = 1'b1;
          if (MEM_next) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      MEM_over = 1'b0;
      wen_en   = 1'b0;
    end
  end

  // State register and captured load value
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      load_reg <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture) load_reg <= load_ext;
    end
  end

  logic [31:0] mem_result;

  assign mem_result = (load & ~adel)
                    ? ((state == LOAD_WAIT) ? load_ext : load_reg)
                    : exe_result;

  assign MEM_WB_bus = {rf_wen & ~adel, rf_wdest, mem_result,
                       lo_result, ctl_bits, cp0r_addr,
                       syscall, eret, brk, ov, adel, ades,
                       badvaddr, pc};

  assign MEM_wdest = rf_wdest & {5{MEM_valid}};
  assign MEM_pc    = pc;

endmodule
